servo_frame_scheduler: RTL

- Sits between the SPI receive front end and the servo PWM channel bank; single-clock replacement for the two-clock buffer sequencing.
- Collects 9-bit SPI words into a frame store and commits the frame on the terminator word 9'h100.
- Dispatches stored words in order to servo channels, assigned round-robin by word position, over a valid/ready handshake.
- Handles overflow, empty frames and words that arrive mid-dispatch deterministically.

---
 rtl/servo_frame_scheduler_pkg.sv | 16 +
 rtl/servo_frame_scheduler_if.sv | 27 ++
 rtl/servo_frame_ram.sv | 25 ++
 rtl/servo_frame_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/servo_frame_scheduler_pkg.sv
// Shared types and constants for the servo frame scheduler.
// Word values with special meaning on the SPI receive path.
package servo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD,
    DISPATCH
  } sched_state_t;

  localparam int WORD_W = 9;
  localparam logic [WORD_W-1:0] TERM_WORD = 9'h100;
  localparam logic [WORD_W-1:0] IDLE_WORD = 9'h000;

endpackage

// File: rtl/servo_frame_scheduler_if.sv
// Valid/ready command bus from the scheduler to the servo channel bank.
interface servo_frame_scheduler_if #(
  parameter int NUM_CH = 8
) ();
  import servo_sched_pkg::*;

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CHW-1:0]    cmd_ch;
  logic [WORD_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_ch,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ch,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/servo_frame_ram.sv
// Frame store: simple dual-port, synchronous write, registered read.
// Contents are never reset; the read register only loads on re_i.
module servo_frame_ram
  import servo_sched_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Collects SPI words into a frame and dispatches them round-robin.
// Optional SCHED_TIMEOUT_EN adds a fill-inactivity timeout.
module servo_frame_scheduler
  import servo_sched_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int NUM_CH      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [WORD_W-1:0] rx_data,
  servo_frame_scheduler_if.master cmd,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf_err,
`ifdef SCHED_TIMEOUT_EN
  output logic              drop_err,
  output logic              timeout_err
`else
  output logic              drop_err
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sched_state_t      state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;

  logic              we, re;
  logic [AW-1:0]     waddr;
  logic [WORD_W-1:0] rdata;

  logic rx_word, payload, term, last;

  assign rx_word = rx_valid && (rx_data != IDLE_WORD);
  assign term    = rx_word && (rx_data == TERM_WORD);
  assign payload = rx_word && (rx_data != TERM_WORD);
  assign last    = (CW'(rd_ptr_q) + CW'(1)) == count_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  servo_frame_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (rx_data),
    .re_i    (re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ch_d     = ch_q;
    vld_d    = vld_q;
    done_d   = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    waddr    = count_q[AW-1:0];
    ovf_err  = 1'b0;
    drop_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (payload) begin
          we      = 1'b1;
          waddr   = '0;
          count_d = CW'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (term) begin
          state_d  = DISPATCH;
          rd_ptr_d = '0;
          ch_d     = '0;
          vld_d    = 1'b0;
        end else if (payload) begin
          if (count_q == CW'(DEPTH)) begin
            state_d = DISCARD;
            ovf_err = 1'b1;
          end else begin
            we      = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
      end
      DISCARD: begin
        if (term) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      DISPATCH: begin
        drop_err = rx_word;
        // Read is issued while invalid; data lands with cmd_valid.
        if (!vld_q) begin
          re    = 1'b1;
          vld_d = 1'b1;
        end else if (cmd.cmd_ready) begin
          vld_d = 1'b0;
          if (last) begin
            state_d  = IDLE;
            count_d  = '0;
            rd_ptr_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            ch_d = (ch_q == CHW'(NUM_CH - 1)) ? '0 : ch_q + CHW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SCHED_TIMEOUT_EN
    to_d        = '0;
    timeout_err = 1'b0;
    if ((state_q == FILL || state_q == DISCARD) && !rx_valid) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        timeout_err = 1'b1;
        state_d     = IDLE;
        count_d     = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      ch_q     <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ch_q     <= ch_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`endif

  assign cmd.cmd_valid = vld_q;
  assign cmd.cmd_data  = vld_q ? rdata : '0;
  assign cmd.cmd_ch    = vld_q ? ch_q : '0;
  assign busy          = (state_q != IDLE);
  assign frame_done    = done_q;

endmodule
